// File: rtl/fpu_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_addsub_arbiter (with datapath Addition_Subtraction)
// Description : Shares one combinational FP32 add/sub datapath among NREQ
//               requesters. Valid/ready request handshake, registered
//               operands, registered result returned only to the granted
//               requester. One operation in flight at a time.
//               Optional build macro FPU_ARB_ROUND_ROBIN_EN selects
//               round-robin arbitration; otherwise fixed priority
//               (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Addition_Subtraction: combinational IEEE-754 single-precision add/sub.
// Truncating alignment and normalisation, no rounding. Any operand with an
// all-ones exponent raises Exception and forces the result to zero.
// ----------------------------------------------------------------------------
module Addition_Subtraction (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        add_sub,
    output logic        Exception,
    output logic [31:0] result
);
    logic [31:0] w_b_eff;
    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [23:0] w_big_m;
    logic [23:0] w_small_m;
    logic [23:0] w_small_al;
    logic [24:0] w_sum_m;
    logic [23:0] w_diff_m;
    logic [23:0] w_norm_m;
    logic [7:0]  w_exp_diff;
    logic [7:0]  w_sum_exp;
    logic [4:0]  w_lz;
    logic [8:0]  w_exp_out;

    // Align the smaller-magnitude operand, add or subtract mantissas, normalise
    always_comb begin
        Exception  = (&a_operand[30:23]) | (&b_operand[30:23]);
        result     = 32'd0;
        w_exp_out  = 9'd0;
        // Subtraction is addition with B's sign flipped
        w_b_eff    = {b_operand[31] ^ add_sub, b_operand[30:0]};
        if (a_operand[30:0] >= w_b_eff[30:0]) begin
            w_big   = a_operand;
            w_small = w_b_eff;
        end else begin
            w_big   = w_b_eff;
            w_small = a_operand;
        end
        // Hidden bit is absent for zero/denormal exponents
        w_big_m    = {|w_big[30:23], w_big[22:0]};
        w_small_m  = {|w_small[30:23], w_small[22:0]};
        w_exp_diff = w_big[30:23] - w_small[30:23];
        w_small_al = (w_exp_diff > 8'd23) ? 24'd0 : (w_small_m >> w_exp_diff);
        w_sum_m    = {1'b0, w_big_m} + {1'b0, w_small_al};
        w_diff_m   = w_big_m - w_small_al;
        // Two denormals may carry into the hidden bit position
        w_sum_exp  = ((w_big[30:23] == 8'd0) && w_sum_m[23]) ? 8'd1 : w_big[30:23];

        // Leading-zero count of the difference; the highest set bit wins
        w_lz = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (w_diff_m[i]) begin
                w_lz = 5'(23 - i);
            end
        end
        w_norm_m = w_diff_m << w_lz;

        if (Exception) begin
            result = 32'd0;
        end else if (w_big[31] == w_small[31]) begin
            if (w_sum_m[24]) begin
                w_exp_out = {1'b0, w_big[30:23]} + 9'd1;
                if (w_exp_out >= 9'd255) begin
                    result = {w_big[31], 8'hFF, 23'd0};
                end else begin
                    result = {w_big[31], w_exp_out[7:0], w_sum_m[23:1]};
                end
            end else begin
                result = {w_big[31], w_sum_exp, w_sum_m[22:0]};
            end
        end else if (w_diff_m == 24'd0) begin
            // Exact cancellation gives +0
            result = 32'd0;
        end else if ({1'b0, w_big[30:23]} <= {4'd0, w_lz}) begin
            // Normalisation would underflow the exponent: flush to signed zero
            result = {w_big[31], 31'd0};
        end else begin
            result = {w_big[31], w_big[30:23] - {3'd0, w_lz}, w_norm_m[22:0]};
        end
    end
endmodule

// ----------------------------------------------------------------------------
// fpu_addsub_arbiter: top level
// ----------------------------------------------------------------------------
module fpu_addsub_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_exception,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [IDW-1:0] w_winner;
    logic           w_found;
    logic           w_take;

    logic [31:0]    w_sel_a;
    logic [31:0]    w_sel_b;
    logic           w_sel_sub;

    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic           r_sub;
    logic [IDW-1:0] r_grant;
    logic [31:0]    r_result;
    logic           r_exc;

    logic [31:0]    w_dp_result;
    logic           w_dp_exc;

`ifdef FPU_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] r_ptr;
    logic [IDW:0]   w_idx;

    // Round-robin pick: scan from ptr upward; descending loop leaves the
    // candidate nearest to ptr as the final assignment
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (IDW + 1)'(k);
            if (w_idx >= (IDW + 1)'(NREQ)) begin
                w_idx = w_idx - (IDW + 1)'(NREQ);
            end
            if (req_valid[w_idx[IDW-1:0]]) begin
                w_winner = w_idx[IDW-1:0];
                w_found  = 1'b1;
            end
        end
    end

    // Priority pointer moves just past the requester that was granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_take) begin
            if (w_winner == IDW'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_winner + 1'b1;
            end
        end
    end
`else
    // Fixed priority pick: lowest valid index wins
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_winner = IDW'(k);
                w_found  = 1'b1;
            end
        end
    end
`endif

    // Route the winning requester's operands towards the operand registers
    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_sel_a   = req_a[32*i +: 32];
                w_sel_b   = req_b[32*i +: 32];
                w_sel_sub = req_sub[i];
            end
        end
    end

    // Next-state and handshake outputs; ready/valid only in their own states
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    req_ready[w_winner] = 1'b1;
                    w_take              = 1'b1;
                    w_state_nxt         = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[r_grant] = 1'b1;
                if (rsp_ready[r_grant]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operands and grant index are sampled only at the request handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_grant <= '0;
        end else if (w_take) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_sub   <= w_sel_sub;
            r_grant <= w_winner;
        end
    end

    Addition_Subtraction u_datapath (
        .a_operand (r_a),
        .b_operand (r_b),
        .add_sub   (r_sub),
        .Exception (w_dp_exc),
        .result    (w_dp_result)
    );

    // Capture the datapath output at the end of EXEC; held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_result <= w_dp_result;
            r_exc    <= w_dp_exc;
        end
    end

    assign rsp_result    = r_result;
    assign rsp_exception = r_exc;
    assign busy          = (r_state != ST_IDLE);
    assign grant_id      = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fpu_addsub_arbiter
// Description : Self-checking bench for fpu_addsub_arbiter. Expected
//               responses are queued when a request handshake is driven and
//               compared when the matching response appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_addsub_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     req_sub;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [31:0]         rsp_result;
    logic                rsp_exception;
    logic                busy;
    logic [IDW-1:0]      grant_id;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    res;
        logic           exc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Per-requester contention operands with hand-computed results:
    // 1+2=3, 3-1=2, 1.5+2.5=4, 2-3=-1
    logic [31:0] c_a   [NREQ] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h40000000};
    logic [31:0] c_b   [NREQ] = '{32'h40000000, 32'h3F800000, 32'h40200000, 32'h40400000};
    logic        c_sub [NREQ] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] c_res [NREQ] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'hBF800000};

    fpu_addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_sub       (req_sub),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_exception (rsp_exception),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sub[i]        = s;
    endtask

    // Waits on negedges for any rsp_valid; cyc = negedges waited, -1 on timeout
    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid == '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (rsp_valid == '0) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake req_ready=%b rsp_valid=%b want 0000/0000", req_ready, rsp_valid);
        end
        checks++;
        if (rsp_result !== 32'h0 || rsp_exception !== 1'b0) begin
            errors++;
            $display("FAIL reset_result got %h/%b want 00000000/0", rsp_result, rsp_exception);
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_busy_grant got busy=%b grant=%0d want 0/0", busy, grant_id);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        exp_t e;
        int   cyc;
        @(negedge clk);
        set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL add_req_ready got %b want 0001", req_ready);
        end
        sb.push_back('{id: 2'd0, res: 32'h40400000, exc: 1'b0});
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL add_exec got busy=%b rsp_valid=%b req_ready=%b want 1/0000/0000", busy, rsp_valid, req_ready);
        end
        wait_rsp(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL add_latency got %0d want 1 cycle after exec", cyc);
        end
        if (cyc >= 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (rsp_valid !== (4'b0001 << e.id) || rsp_result !== e.res || rsp_exception !== e.exc) begin
                errors++;
                $display("FAIL add_rsp got v=%b r=%h x=%b want v=%b r=%h x=%b",
                         rsp_valid, rsp_result, rsp_exception, 4'b0001 << e.id, e.res, e.exc);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL add_done got busy=%b rsp_valid=%b want 0/0000", busy, rsp_valid);
        end
    endtask

    task automatic test_single_sub();
        exp_t e;
        int   cyc;
        @(negedge clk);
        set_op(2, 32'h40400000, 32'h3F800000, 1'b1);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL sub_req_ready got %b want 0100", req_ready);
        end
        sb.push_back('{id: 2'd2, res: 32'h40000000, exc: 1'b0});
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL sub_latency got %0d want 1", cyc);
        end
        if (cyc >= 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (rsp_valid !== 4'b0100 || rsp_result !== e.res || grant_id !== e.id || rsp_exception !== e.exc) begin
                errors++;
                $display("FAIL sub_rsp got v=%b r=%h g=%0d x=%b want v=0100 r=%h g=%0d x=%b",
                         rsp_valid, rsp_result, grant_id, rsp_exception, e.res, e.id, e.exc);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_exception();
        exp_t e;
        int   cyc;
        @(negedge clk);
        set_op(1, 32'h7F800000, 32'h3F800000, 1'b0);
        req_valid = 4'b0010;
        sb.push_back('{id: 2'd1, res: 32'h00000000, exc: 1'b1});
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc);
        checks++;
        if (cyc < 0 || sb.size() == 0) begin
            errors++;
            $display("FAIL exc_timeout got cyc=%0d want 1", cyc);
        end else begin
            e = sb.pop_front();
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_result !== e.res || rsp_exception !== e.exc) begin
                errors++;
                $display("FAIL exc_rsp got v=%b r=%h x=%b want v=0010 r=%h x=%b",
                         rsp_valid, rsp_result, rsp_exception, e.res, e.exc);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_resp();
        int cyc;
        bit stale;
        @(negedge clk);
        set_op(0, 32'h3FC00000, 32'h40200000, 1'b0);
        req_valid = 4'b0001;
        sb.push_back('{id: 2'd0, res: 32'h40800000, exc: 1'b0});
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 32'h40800000) begin
            errors++;
            $display("FAIL rstmid_pre got v=%b r=%h want 0001/40800000", rsp_valid, rsp_result);
        end
        rsp_ready = '0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000 || busy !== 1'b0 ||
            rsp_result !== 32'h0 || rsp_exception !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_async got v=%b rdy=%b busy=%b r=%h x=%b g=%0d want all zero",
                     rsp_valid, req_ready, busy, rsp_result, rsp_exception, grant_id);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = '1;
        stale     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL rstmid_stale got rsp_valid=%b busy=%b want 0000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_contention();
`ifdef FPU_ARB_ROUND_ROBIN_EN
        int   exp_ids [5] = '{0, 1, 2, 3, 0};
        int   ngr = 5;
`else
        int   exp_ids [5] = '{0, 0, 0, 0, 0};
        int   ngr = 3;
`endif
        int   ids[$];
        int   at[$];
        int   n_rsp = 0;
        int   cyc = 0;
        int   idx;
        exp_t e;
        for (int i = 0; i < NREQ; i++) set_op(i, c_a[i], c_b[i], c_sub[i]);
        rsp_ready = '1;
        req_valid = '1;
        while (n_rsp < ngr && cyc < 60) begin
            #1;
            if ((req_valid & req_ready) != '0) begin
                idx = -1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
                ids.push_back(idx);
                at.push_back(cyc);
                sb.push_back('{id: IDW'(idx), res: c_res[idx], exc: 1'b0});
            end
            if (rsp_valid != '0 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (rsp_valid !== (4'b0001 << e.id) || rsp_result !== e.res || rsp_exception !== e.exc) begin
                    errors++;
                    $display("FAIL cont_rsp got v=%b r=%h x=%b want v=%b r=%h x=%b",
                             rsp_valid, rsp_result, rsp_exception, 4'b0001 << e.id, e.res, e.exc);
                end
                n_rsp++;
                if (n_rsp == ngr) req_valid = '0;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (n_rsp != ngr || ids.size() < ngr) begin
            errors++;
            $display("FAIL cont_count got rsp=%0d grants=%0d want %0d", n_rsp, ids.size(), ngr);
        end else begin
            for (int k = 0; k < ngr; k++) begin
                checks++;
                if (ids[k] != exp_ids[k]) begin
                    errors++;
                    $display("FAIL cont_order[%0d] got %0d want %0d", k, ids[k], exp_ids[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (at[k] - at[k-1] != 3) begin
                        errors++;
                        $display("FAIL cont_interval[%0d] got %0d want 3", k, at[k] - at[k-1]);
                    end
                end
            end
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        @(negedge clk);
        rsp_ready = 4'b1101;
        set_op(1, c_a[2], c_b[2], c_sub[2]);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_req_ready got %b want 0010", req_ready);
        end
        sb.push_back('{id: 2'd1, res: 32'h40800000, exc: 1'b0});
        @(negedge clk);
        set_op(3, c_a[3], c_b[3], c_sub[3]);
        req_valid = 4'b1000;
        wait_rsp(cyc);
        checks++;
        if (cyc != 1 || sb.size() == 0) begin
            errors++;
            $display("FAIL bp_latency got %0d want 1", cyc);
        end else begin
            e = sb.pop_front();
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_result !== e.res) begin
                errors++;
                $display("FAIL bp_rsp got v=%b r=%h want 0010/%h", rsp_valid, rsp_result, e.res);
            end
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                checks++;
                if (rsp_valid !== 4'b0010 || rsp_result !== e.res || rsp_exception !== 1'b0 ||
                    grant_id !== 2'd1 || req_ready !== 4'b0000) begin
                    errors++;
                    $display("FAIL bp_hold[%0d] got v=%b r=%h x=%b g=%0d rdy=%b want 0010/%h/0/1/0000",
                             k, rsp_valid, rsp_result, rsp_exception, grant_id, req_ready, e.res);
                end
            end
        end
        rsp_ready = '1;
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b1000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_grant got rdy=%b busy=%b want 1000/0", req_ready, busy);
        end
        sb.push_back('{id: 2'd3, res: 32'hBF800000, exc: 1'b0});
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc);
        checks++;
        if (cyc != 1 || sb.size() == 0) begin
            errors++;
            $display("FAIL bp_r3_latency got %0d want 1", cyc);
        end else begin
            e = sb.pop_front();
            checks++;
            if (rsp_valid !== 4'b1000 || rsp_result !== e.res || grant_id !== e.id) begin
                errors++;
                $display("FAIL bp_r3_rsp got v=%b r=%h g=%0d want 1000/%h/%0d",
                         rsp_valid, rsp_result, grant_id, e.res, e.id);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_end got busy=%b pending=%0d want 0/0", busy, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_single_sub();
        test_exception();
        test_reset_mid_resp();
        test_contention();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
